uart_tx_tick: RTL and testbench

Serial transmitter that sits directly downstream of ClkDivider. ClkDivider runs in pulse mode and produces a one-clk-wide baud_tick. This block buffers bytes from the CPU/bus side in a small FIFO and shifts them out as UART frames: start bit, data bits LSB-first, optional parity, stop bit(s). All frame timing comes from baud_tick; the block has no rate counter of its own.

---
 rtl/uart_tx_tick.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_tick.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_tick.sv
// uart_tx_tick
// ------------
// UART transmitter driven by an external one-clk-wide baud_tick (ClkDivider
// in pulse mode). Bytes from the bus side are buffered in a small FIFO and
// shifted out as frames: start bit, DATA_BITS data bits LSB-first, optional
// parity bit, STOP_BITS stop bits. The block has no rate counter of its own:
// every change on tx_o happens on a clk edge where baud_tick is high, so each
// bit lasts exactly one tick period. Frames go out back-to-back with no idle
// gap while the FIFO is non-empty and tx_enable is high.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-low reset
//   baud_tick     one-cycle pulse per bit period (may be held high: 1 bit/clk)
//   tx_enable     permits new frames to start (sampled only at frame start)
//   data_i        byte to transmit
//   valid_i       data_i valid; pushed when valid_i && ready_o
//   ready_o       FIFO can accept a byte (combinational !full)
//   tx_o          serial line, idle high, registered
//   busy_o        frame in progress (FSM not in IDLE)
//   fifo_count_o  entries currently buffered (0..FIFO_DEPTH)

module uart_tx_tick #(
    parameter int DATA_BITS  = 8,  // 5..9
    parameter int FIFO_DEPTH = 4,  // power of 2, >= 2
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1   // 1 or 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          baud_tick,
    input  logic                          tx_enable,
    input  logic [DATA_BITS-1:0]          data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [ADDR_W-1:0] PTR_ONE   = 1;
    localparam logic [ADDR_W:0]   CNT_ONE   = 1;
    localparam logic [ADDR_W:0]   CNT_FULL  = FIFO_DEPTH;
    localparam logic [BIT_W-1:0]  BIT_ONE   = 1;
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic              PAR_INIT  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]    wr_ptr;
    logic [ADDR_W-1:0]    rd_ptr;
    logic [ADDR_W:0]      count;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t               state;
    logic [DATA_BITS-1:0] shift;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic                 parity;
    logic                 start_frame;

    assign ready_o    = (count != CNT_FULL);
    assign fifo_empty = (count == '0);
    assign push       = valid_i && ready_o;

    // A frame starts on a tick from IDLE, or on the tick that ends the last
    // stop bit of the previous frame (back-to-back, no idle gap). The FIFO
    // head is popped on that same edge.
    assign start_frame = baud_tick && tx_enable && !fifo_empty &&
                         ((state == IDLE) || ((state == STOP) && (stop_cnt == STOP_LAST)));
    assign pop         = start_frame;

    assign busy_o       = (state != IDLE);
    assign fifo_count_o = count;

    // NOTE: FIFO storage carries no reset; only the pointers and count define
    // which entries are valid, so clearing the array would be wasted logic.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            // Simultaneous push and pop leave the count unchanged.
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tx_o     <= 1'b1;
            shift    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            parity   <= 1'b0;
        end else if (start_frame) begin
            shift    <= mem[rd_ptr];
            tx_o     <= 1'b0;
            bit_cnt  <= '0;
            parity   <= PAR_INIT;
            state    <= START;
        end else if (baud_tick) begin
            case (state)
                IDLE: begin
                    tx_o <= 1'b1;
                end
                START: begin
                    tx_o   <= shift[0];
                    shift  <= shift >> 1;
                    parity <= parity ^ shift[0];
                    state  <= DATA;
                end
                DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        stop_cnt <= 1'b0;
                        if (PARITY_EN != 0) begin
                            tx_o  <= parity;
                            state <= PARITY;
                        end else begin
                            tx_o  <= 1'b1;
                            state <= STOP;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BIT_ONE;
                        tx_o    <= shift[0];
                        shift   <= shift >> 1;
                        parity  <= parity ^ shift[0];
                    end
                end
                PARITY: begin
                    tx_o     <= 1'b1;
                    stop_cnt <= 1'b0;
                    state    <= STOP;
                end
                STOP: begin
                    // The back-to-back case was already taken by start_frame.
                    if (stop_cnt != STOP_LAST) begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end else begin
                        tx_o  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    tx_o  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_tick.sv
// Directed testbench for uart_tx_tick. Two instances share clk, reset,
// baud_tick, tx_enable and data_i: dut uses the default parameters, dut_p
// uses even/odd parity enabled (odd) with two stop bits.

module tb_uart_tx_tick;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baud_tick = 1'b0;
    logic       tx_enable = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       valid_i = 1'b0;
    logic       valid_p = 1'b0;

    logic       ready_o, tx_o, busy_o;
    logic [2:0] fifo_count_o;
    logic       ready_p, tx_p, busy_p;
    logic [2:0] count_p;

    int n_cmp = 0;
    int n_err = 0;
    int tick_mode = 0;  // 0: no ticks, 1: one tick every 4 clks, 2: stuck high

    always #5 clk = ~clk;

    uart_tx_tick dut (
        .clk          (clk),
        .reset        (reset),
        .baud_tick    (baud_tick),
        .tx_enable    (tx_enable),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .fifo_count_o (fifo_count_o)
    );

    uart_tx_tick #(
        .PARITY_EN  (1),
        .PARITY_ODD (1),
        .STOP_BITS  (2)
    ) dut_p (
        .clk          (clk),
        .reset        (reset),
        .baud_tick    (baud_tick),
        .tx_enable    (tx_enable),
        .data_i       (data_i),
        .valid_i      (valid_p),
        .ready_o      (ready_p),
        .tx_o         (tx_p),
        .busy_o       (busy_p),
        .fifo_count_o (count_p)
    );

    // Tick generator: updates 1 time unit after each rising edge, so the
    // value seen at a falling edge is the one the next rising edge samples.
    initial begin : tick_gen
        int div;
        div = 0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_mode == 2) begin
                baud_tick = 1'b1;
            end else if (tick_mode == 1) begin
                div = (div + 1) % 4;
                baud_tick = (div == 0);
            end else begin
                baud_tick = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Frame vector for the default instance: bit0 start, bits1-8 data, bit9 stop.
    function automatic logic [11:0] frame8(input logic [7:0] d);
        return {3'b001, d, 1'b0};
    endfunction

    task automatic push(input bit sel, input logic [7:0] d);
        @(negedge clk);
        data_i = d;
        if (sel) valid_p = 1'b1;
        else     valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        valid_p = 1'b0;
    endtask

    // Waits (bounded) for the start bit, checks the FIFO count at frame start,
    // then checks tx and busy on every clk of every bit.
    task automatic check_frame(input string name, input bit sel, input logic [11:0] bits,
                               input int nbits, input int spb, input int max_wait,
                               input int exp_cnt);
        bit         found;
        logic       tx_v, busy_v;
        logic [2:0] cnt_v;
        found = 1'b0;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            tx_v = sel ? tx_p : tx_o;
            if (tx_v === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!found) begin
            $display("FAIL %s start: no start bit within %0d clks", name, max_wait);
            n_err++;
            return;
        end
        cnt_v = sel ? count_p : fifo_count_o;
        n_cmp++;
        if (cnt_v !== 3'(exp_cnt)) begin
            $display("FAIL %s count at start: got %0d expected %0d", name, cnt_v, exp_cnt);
            n_err++;
        end
        for (int b = 0; b < nbits; b++) begin
            for (int s = 0; s < spb; s++) begin
                if (b != 0 || s != 0) @(negedge clk);
                tx_v   = sel ? tx_p : tx_o;
                busy_v = sel ? busy_p : busy_o;
                n_cmp++;
                if (tx_v !== bits[b] || busy_v !== 1'b1) begin
                    $display("FAIL %s bit %0d clk %0d: tx=%b busy=%b expected tx=%b busy=1",
                             name, b, s, tx_v, busy_v, bits[b]);
                    n_err++;
                end
            end
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0 || fifo_count_o !== 3'd0 || ready_o !== 1'b1) begin
            $display("FAIL reset dut: tx=%b busy=%b count=%0d ready=%b expected 1 0 0 1",
                     tx_o, busy_o, fifo_count_o, ready_o);
            n_err++;
        end
        n_cmp++;
        if (tx_p !== 1'b1 || busy_p !== 1'b0 || count_p !== 3'd0 || ready_p !== 1'b1) begin
            $display("FAIL reset dut_p: tx=%b busy=%b count=%0d ready=%b expected 1 0 0 1",
                     tx_p, busy_p, count_p, ready_p);
            n_err++;
        end
        reset = 1'b1;
        tick_mode = 1;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
            $display("FAIL idle after reset: tx=%b busy=%b expected 1 0", tx_o, busy_o);
            n_err++;
        end
    endtask

    task automatic test_single_byte();
        tx_enable = 1'b1;
        push(1'b0, 8'hA5);
        n_cmp++;
        if (fifo_count_o !== 3'd1) begin
            $display("FAIL single count after push: got %0d expected 1", fifo_count_o);
            n_err++;
        end
        check_frame("single_a5", 1'b0, frame8(8'hA5), 10, 4, 8, 0);
        @(negedge clk);
        n_cmp++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0 || fifo_count_o !== 3'd0) begin
            $display("FAIL single end: tx=%b busy=%b count=%0d expected 1 0 0",
                     tx_o, busy_o, fifo_count_o);
            n_err++;
        end
    endtask

    task automatic test_fifo_full();
        tx_enable = 1'b0;
        for (int i = 1; i <= 4; i++) push(1'b0, 8'(i));
        n_cmp++;
        if (ready_o !== 1'b0 || fifo_count_o !== 3'd4) begin
            $display("FAIL full: ready=%b count=%0d expected 0 4", ready_o, fifo_count_o);
            n_err++;
        end
        @(negedge clk);
        data_i  = 8'h05;
        valid_i = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (ready_o !== 1'b0 || fifo_count_o !== 3'd4 || tx_o !== 1'b1) begin
            $display("FAIL full hold: ready=%b count=%0d tx=%b expected 0 4 1",
                     ready_o, fifo_count_o, tx_o);
            n_err++;
        end
        tx_enable = 1'b1;
        fork
            begin
                check_frame("b2b_01", 1'b0, frame8(8'h01), 10, 4, 8, 3);
                check_frame("b2b_02", 1'b0, frame8(8'h02), 10, 4, 1, 3);
                check_frame("b2b_03", 1'b0, frame8(8'h03), 10, 4, 1, 2);
                check_frame("b2b_04", 1'b0, frame8(8'h04), 10, 4, 1, 1);
                check_frame("b2b_05", 1'b0, frame8(8'h05), 10, 4, 1, 0);
            end
            begin
                bit acc;
                acc = 1'b0;
                for (int i = 0; i < 12; i++) begin
                    @(negedge clk);
                    if (ready_o === 1'b1) begin
                        acc = 1'b1;
                        @(negedge clk);
                        valid_i = 1'b0;
                        break;
                    end
                end
                n_cmp++;
                if (!acc) begin
                    $display("FAIL held push: ready never rose, got 0 expected 1");
                    n_err++;
                    valid_i = 1'b0;
                end
            end
        join
        @(negedge clk);
        n_cmp++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0 || fifo_count_o !== 3'd0 || ready_o !== 1'b1) begin
            $display("FAIL b2b end: tx=%b busy=%b count=%0d ready=%b expected 1 0 0 1",
                     tx_o, busy_o, fifo_count_o, ready_o);
            n_err++;
        end
    endtask

    task automatic test_parity_stop();
        logic [11:0] exp_bits;
        // 07 -> data 1,1,1,0,0,0,0,0; odd parity of three ones = 0; two stops.
        exp_bits = 12'hC0E;
        tx_enable = 1'b1;
        push(1'b1, 8'h07);
        check_frame("parity_07", 1'b1, exp_bits, 12, 4, 8, 0);
        @(negedge clk);
        n_cmp++;
        if (tx_p !== 1'b1 || busy_p !== 1'b0) begin
            $display("FAIL parity end: tx=%b busy=%b expected 1 0", tx_p, busy_p);
            n_err++;
        end
    endtask

    task automatic test_enable_drop();
        tx_enable = 1'b0;
        push(1'b0, 8'h3C);
        push(1'b0, 8'hC3);
        tx_enable = 1'b1;
        fork
            check_frame("drop_3c", 1'b0, frame8(8'h3C), 10, 4, 8, 1);
            begin
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    if (busy_o === 1'b1) break;
                end
                repeat (16) @(negedge clk);  // now in data bit 3
                tx_enable = 1'b0;
            end
        join
        @(negedge clk);
        n_cmp++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0 || fifo_count_o !== 3'd1) begin
            $display("FAIL drop end: tx=%b busy=%b count=%0d expected 1 0 1",
                     tx_o, busy_o, fifo_count_o);
            n_err++;
        end
        repeat (12) @(negedge clk);
        n_cmp++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0 || fifo_count_o !== 3'd1) begin
            $display("FAIL drop hold: tx=%b busy=%b count=%0d expected 1 0 1",
                     tx_o, busy_o, fifo_count_o);
            n_err++;
        end
        tx_enable = 1'b1;
        check_frame("drop_c3", 1'b0, frame8(8'hC3), 10, 4, 4, 0);
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        tx_enable = 1'b0;
        push(1'b0, 8'h00);
        push(1'b0, 8'h00);
        tx_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy_o === 1'b1) break;
        end
        repeat (8) @(negedge clk);  // data bit 1 of an all-zero byte
        n_cmp++;
        if (tx_o !== 1'b0 || busy_o !== 1'b1 || fifo_count_o !== 3'd1) begin
            $display("FAIL pre-reset: tx=%b busy=%b count=%0d expected 0 1 1",
                     tx_o, busy_o, fifo_count_o);
            n_err++;
        end
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0 || fifo_count_o !== 3'd0 || ready_o !== 1'b1) begin
            $display("FAIL async reset: tx=%b busy=%b count=%0d ready=%b expected 1 0 0 1",
                     tx_o, busy_o, fifo_count_o, ready_o);
            n_err++;
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_cmp++;
            if (tx_o !== 1'b1 || busy_o !== 1'b0 || fifo_count_o !== 3'd0) begin
                $display("FAIL post-reset idle clk %0d: tx=%b busy=%b count=%0d expected 1 0 0",
                         i, tx_o, busy_o, fifo_count_o);
                n_err++;
            end
        end
    endtask

    task automatic test_push_pop();
        bit aligned;
        tx_enable = 1'b0;
        push(1'b0, 8'h5A);
        aligned = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (baud_tick === 1'b1) begin
                tx_enable = 1'b1;
                data_i    = 8'hA6;
                valid_i   = 1'b1;
                aligned   = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!aligned) begin
            $display("FAIL push_pop align: no tick seen, got 0 expected 1");
            n_err++;
            valid_i = 1'b0;
            tx_enable = 1'b1;
        end
        fork
            check_frame("pp_5a", 1'b0, frame8(8'h5A), 10, 4, 1, 1);
            begin
                @(negedge clk);
                valid_i = 1'b0;
            end
        join
        check_frame("pp_a6", 1'b0, frame8(8'hA6), 10, 4, 1, 0);
        @(negedge clk);
        n_cmp++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0 || fifo_count_o !== 3'd0) begin
            $display("FAIL push_pop end: tx=%b busy=%b count=%0d expected 1 0 0",
                     tx_o, busy_o, fifo_count_o);
            n_err++;
        end
    endtask

    task automatic test_fast_tick();
        tick_mode = 2;
        tx_enable = 1'b1;
        push(1'b0, 8'h96);
        n_cmp++;
        if (fifo_count_o !== 3'd1) begin
            $display("FAIL fast count after push: got %0d expected 1", fifo_count_o);
            n_err++;
        end
        check_frame("fast_96", 1'b0, frame8(8'h96), 10, 1, 2, 0);
        @(negedge clk);
        n_cmp++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
            $display("FAIL fast end: tx=%b busy=%b expected 1 0", tx_o, busy_o);
            n_err++;
        end
        tick_mode = 1;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_fifo_full();
        test_parity_stop();
        test_enable_drop();
        test_async_reset();
        test_push_pop();
        test_fast_tick();
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
